alarm_display_mux: RTL and testbench
====================================

# alarm_display_mux

Multi-channel alarm display driver for the liquid-level meter. It takes one 3-bit alarm status code per tank channel, filters each code against sensor jitter, and drives a time-multiplexed bank of common-anode 7-segment digits, one digit per channel. It also adds two things a per-digit combinational decoder cannot provide: a blinking error glyph and a registered any-error flag. It sits between the per-channel level comparators and the board's segment/anode pins.

## Interface
- `DIGITS`, default 4: number of channels and digits (at least 1).
- `SCAN_DIV`, default 100000: clocks per digit slot (at least 2).
- `BLINK_DIV`, default 25000000: clocks per error-blink half-period (at least 1).
- `STABLE_CYCLES`, default 1000: consecutive identical clocks needed before a code is accepted (at least 1).
- `clk` in, 1 bit: system clock, rising edge.
- `reset` in, 1 bit: reset, synchronous, active-high.
- `codes` in, 3*DIGITS bits: channel i code in `codes[3i+2:3i]`.
- `seg` out, 8 bits: segment drive, active-low, bit 7 = a … bit 1 = g, bit 0 = dp.
- `an` out, DIGITS bits: digit enable, active-low; `an[i]` selects channel i.
- `alarm_any` out, 1 bit: high while any accepted code is an error code.

## Operation
- Code map (accepted code to glyph):
  - 000 gives O (`8'hC5`).
  - 001 gives L (`8'hE3`).
  - 010 gives H (`8'h91`).
  - 1xx gives E (`8'h61`).
  - 011 gives blank (`8'hFF`).
- Filter, per channel:
  - A candidate register plus a stability counter.
  - When the raw code differs from the candidate, the candidate is loaded and the counter clears.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
  - The accepted code updates to the candidate when the raw code has been identical for STABLE_CYCLES consecutive clocks.
  - A change during the count restarts the count; there is no partial acceptance.
- Reset value of every accepted code is 011 (blank).
- Scan:
  - The scan counter runs 0..SCAN_DIV-1. On wrap, the digit index advances, wrapping from DIGITS-1 to 0.
  - Slot-start blanking: `an` is all ones for the first clock of every slot to avoid ghosting.
- Blink:
  - Free-running counter 0..BLINK_DIV-1; the blink phase toggles on wrap.
  - Phase 1 replaces E glyphs with blank. O, L and H never blink.
- `alarm_any` is the registered OR of bit 2 of all accepted codes. It does not blink.
- Counter widths are `$clog2` of their modulus, with a minimum of 1. All wraps are by explicit compare, never by natural overflow.
- When `reset` is asserted:
  - All counters, digit index and blink phase go to 0.
  - Accepted codes go to 011.
  - Outputs go to `seg`=`8'hFF`, `an`=all ones, `alarm_any`=0.
  - This is required mid-scan and mid-filter alike.

## Timing
- `seg`, `an` and `alarm_any` are registered. All outputs hold their reset values during reset.
- Slot 0 begins at the first rising edge after `reset` deasserts.
- Each slot lasts SCAN_DIV clocks at the outputs:
  - 1 clock with `an` all ones.
  - Then SCAN_DIV-1 clocks with only `an[i]`=0 and `seg` showing channel i's glyph.
- Latency from a raw code change to the accepted code is STABLE_CYCLES clocks. It reaches `seg` and `alarm_any` one clock later, once the channel's slot is active.
- An accepted code changing mid-slot updates `seg` on the next clock. The slot is not restarted.
- A blink toggle mid-slot takes effect on the next clock.
- When DIGITS=1, the index stays 0. Slot-start blanking still occurs every SCAN_DIV clocks.

## Structure
- Package `alarm_disp_pkg` holds:
  - Code constants: `CODE_OK`=000, `CODE_LOW`=001, `CODE_HIGH`=010, `CODE_BLANK`=011, `CODE_ERR_BIT`=2.
  - Glyph constants: `GLYPH_O`, `GLYPH_L`, `GLYPH_H`, `GLYPH_E`, `GLYPH_OFF`.
  - A function mapping a code to its glyph.
- Sub-module `alarm_code_filter` is parameterised by STABLE_CYCLES and holds one channel's candidate, counter and accepted code. It is instantiated DIGITS times from a generate loop.
- The top level holds the scan counter, digit index, blink logic and output registers.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, BLINK_DIV=16, STABLE_CYCLES=3.
1. Reset release with `codes`=0 → `an` sequence repeats 1111, 1110, 1110, 1110, 1111, 1101…. `seg`=`FF` until the codes are accepted, then `C5`.
2. Channel 2 steady at 001 → accepted 3 clocks after the change. During slot 2, `seg`=`E3` with `an`=1011.
3. Channel 1 toggles 010/000 every 2 clocks for 20 clocks → the accepted code never changes from its prior value. Once held at 010 for 3 clocks → `H` (`91`) appears.
4. Channel 3 = 100 → `alarm_any`=1 one clock after acceptance. The slot-3 glyph alternates between `61` and `FF` every 16 clocks. `alarm_any` stays 1 throughout.
5. All channels at 011 → `seg`=`FF` in every slot and `alarm_any`=0.
6. Assert `reset` for one clock mid-slot 2 with an error accepted → next clock `seg`=`FF`, `an`=1111, `alarm_any`=0. Scanning restarts at slot 0, and the error reappears only after 3 stable clocks.

Source files
------------

// File: rtl/alarm_disp_pkg.sv
// Shared code/glyph constants and helpers for the alarm display driver.
// Glyph bit order: bit 7 = segment a ... bit 1 = segment g, bit 0 = dp, active-low.
package alarm_disp_pkg;

  localparam logic [2:0] CODE_OK      = 3'b000;
  localparam logic [2:0] CODE_LOW     = 3'b001;
  localparam logic [2:0] CODE_HIGH    = 3'b010;
  localparam logic [2:0] CODE_BLANK   = 3'b011;
  localparam int         CODE_ERR_BIT = 2;

  localparam logic [7:0] GLYPH_O   = 8'hC5;
  localparam logic [7:0] GLYPH_L   = 8'hE3;
  localparam logic [7:0] GLYPH_H   = 8'h91;
  localparam logic [7:0] GLYPH_E   = 8'h61;
  localparam logic [7:0] GLYPH_OFF = 8'hFF;

  function automatic logic [7:0] code_to_glyph(input logic [2:0] code);
    logic [7:0] glyph;
    glyph = GLYPH_OFF;
    if (code[CODE_ERR_BIT]) begin
      glyph = GLYPH_E;
    end else begin
      case (code)
        CODE_OK:   glyph = GLYPH_O;
        CODE_LOW:  glyph = GLYPH_L;
        CODE_HIGH: glyph = GLYPH_H;
        default:   glyph = GLYPH_OFF;
      endcase
    end
    return glyph;
  endfunction

  // Counter width for a given modulus; a modulus of 1 still needs one bit.
  function automatic int width_of(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/alarm_code_filter.sv
// One channel's jitter filter: a code is accepted only after it has been
// seen unchanged for STABLE_CYCLES consecutive clocks.
module alarm_code_filter
  import alarm_disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_code,
  output logic [2:0] accepted_code
);

  localparam int            CW      = width_of(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [2:0]    candidate;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // count_next + 1 is the length of the current run of identical raw codes
  always_comb begin
    count_next = '0;
    if (raw_code == candidate) begin
      count_next = (count == CNT_MAX) ? count : count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      candidate     <= CODE_BLANK;
      count         <= '0;
      accepted_code <= CODE_BLANK;
    end else begin
      candidate <= raw_code;
      count     <= count_next;
      if (count_next == CNT_MAX) begin
        accepted_code <= raw_code;
      end
    end
  end

endmodule

// File: rtl/alarm_display_mux.sv
// Multi-channel alarm display: per-channel filtered codes scanned onto a
// common-anode 7-segment bank, with blinking error glyph and any-error flag.
module alarm_display_mux
  import alarm_disp_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int SCAN_DIV      = 100000,
  parameter int BLINK_DIV     = 25000000,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3*DIGITS-1:0]   codes,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  alarm_any
);

  localparam int SW = width_of(SCAN_DIV);
  localparam int DW = width_of(DIGITS);
  localparam int BW = width_of(BLINK_DIV);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [DIGITS-1:0][2:0] accepted;
  logic [SW-1:0]          scan_cnt;
  logic [DW-1:0]          digit;
  logic [BW-1:0]          blink_cnt;
  logic                   blink_phase;

  logic [2:0]             cur_code;
  logic [7:0]             seg_next;
  logic [DIGITS-1:0]      an_next;
  logic                   any_err;

  for (genvar i = 0; i < DIGITS; i++) begin : g_filter
    alarm_code_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
      .clk          (clk),
      .reset        (reset),
      .raw_code     (codes[3*i +: 3]),
      .accepted_code(accepted[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt    <= '0;
      digit       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        digit    <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // First clock of each slot keeps every anode off so the previous digit's
  // segments never ghost onto the newly selected one.
  always_comb begin
    cur_code = accepted[digit];
    seg_next = code_to_glyph(cur_code);
    if (blink_phase && cur_code[CODE_ERR_BIT]) begin
      seg_next = GLYPH_OFF;
    end
    an_next = '1;
    if (scan_cnt == '0) begin
      seg_next = GLYPH_OFF;
    end else begin
      an_next[digit] = 1'b0;
    end
    any_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any_err = any_err | accepted[i][CODE_ERR_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg       <= GLYPH_OFF;
      an        <= '1;
      alarm_any <= 1'b0;
    end else begin
      seg       <= seg_next;
      an        <= an_next;
      alarm_any <= any_err;
    end
  end

endmodule

// File: tb/tb_alarm_display_mux.sv
// Directed bench for alarm_display_mux with DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=16, STABLE_CYCLES=3; k counts rising edges since reset release.
module tb_alarm_display_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] codes;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        alarm_any;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [11:0] codes;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        alarm;
  } vec_t;

  vec_t tbl [16];

  alarm_display_mux #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .BLINK_DIV    (16),
    .STABLE_CYCLES(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .codes    (codes),
    .seg      (seg),
    .an       (an),
    .alarm_any(alarm_any)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic [11:0] c);
    reset = rst;
    codes = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int k, input logic [3:0] exp_an,
                             input logic [7:0] exp_seg, input logic exp_alarm);
    compared++;
    if (an !== exp_an) begin
      mismatched++;
      $display("[TB] FAIL %s k=%0d an: got %b want %b", name, k, an, exp_an);
    end
    compared++;
    if (seg !== exp_seg) begin
      mismatched++;
      $display("[TB] FAIL %s k=%0d seg: got %h want %h", name, k, seg, exp_seg);
    end
    compared++;
    if (alarm_any !== exp_alarm) begin
      mismatched++;
      $display("[TB] FAIL %s k=%0d alarm_any: got %b want %b", name, k, alarm_any, exp_alarm);
    end
  endtask

  function automatic logic [3:0] exp_an(input int k);
    return (k % 4 == 0) ? 4'hF : ~(4'b0001 << ((k / 4) % 4));
  endfunction

  function automatic int slot_of(input int k);
    return (k / 4) % 4;
  endfunction

  initial begin
    logic [11:0] c;
    logic [7:0]  es;

    tbl[0]  = '{12'h000, 4'hF, 8'hFF, 1'b0};
    tbl[1]  = '{12'h000, 4'hE, 8'hFF, 1'b0};
    tbl[2]  = '{12'h000, 4'hE, 8'hFF, 1'b0};
    tbl[3]  = '{12'h000, 4'hE, 8'hC5, 1'b0};
    tbl[4]  = '{12'h000, 4'hF, 8'hFF, 1'b0};
    tbl[5]  = '{12'h000, 4'hD, 8'hC5, 1'b0};
    tbl[6]  = '{12'h000, 4'hD, 8'hC5, 1'b0};
    tbl[7]  = '{12'h000, 4'hD, 8'hC5, 1'b0};
    tbl[8]  = '{12'h000, 4'hF, 8'hFF, 1'b0};
    tbl[9]  = '{12'h000, 4'hB, 8'hC5, 1'b0};
    tbl[10] = '{12'h000, 4'hB, 8'hC5, 1'b0};
    tbl[11] = '{12'h000, 4'hB, 8'hC5, 1'b0};
    tbl[12] = '{12'h000, 4'hF, 8'hFF, 1'b0};
    tbl[13] = '{12'h000, 4'h7, 8'hC5, 1'b0};
    tbl[14] = '{12'h000, 4'h7, 8'hC5, 1'b0};
    tbl[15] = '{12'h000, 4'h7, 8'hC5, 1'b0};

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 12'h000);
      checkOutput("reset_hold", -1, 4'hF, 8'hFF, 1'b0);
    end

    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, tbl[k].codes);
      checkOutput("startup", k, tbl[k].an, tbl[k].seg, tbl[k].alarm);
    end

    // Channel 2 -> 001 just before slot 2 so the 3-clock latency shows on seg
    for (int k = 16; k < 32; k++) begin
      applyStimulus(1'b0, (k >= 24) ? 12'h040 : 12'h000);
      if (k % 4 == 0)                   es = 8'hFF;
      else if (slot_of(k) == 2 && k >= 27) es = 8'hE3;
      else                               es = 8'hC5;
      checkOutput("ch2_low", k, exp_an(k), es, 1'b0);
    end

    // Channel 1 toggles 010/000 every 2 clocks, then holds 010
    for (int k = 32; k < 64; k++) begin
      if (k < 52) c = (((k - 32) / 2) % 2 == 0) ? 12'h050 : 12'h040;
      else        c = 12'h050;
      applyStimulus(1'b0, c);
      if (k % 4 == 0)          es = 8'hFF;
      else if (slot_of(k) == 1) es = (k >= 55) ? 8'h91 : 8'hC5;
      else if (slot_of(k) == 2) es = 8'hE3;
      else                     es = 8'hC5;
      checkOutput("ch1_jitter", k, exp_an(k), es, 1'b0);
    end

    // Channel 3 error: blinks with 16-clock half-period, flag steady
    for (int k = 64; k < 112; k++) begin
      applyStimulus(1'b0, 12'h850);
      case (slot_of(k))
        0:       es = 8'hC5;
        1:       es = 8'h91;
        2:       es = 8'hE3;
        default: es = (((k / 16) % 2) == 1) ? 8'hFF : 8'h61;
      endcase
      if (k % 4 == 0) es = 8'hFF;
      checkOutput("ch3_err_blink", k, exp_an(k), es, (k >= 67));
    end

    // Every channel blank
    for (int k = 112; k < 128; k++) begin
      applyStimulus(1'b0, 12'h6DB);
      es = (k % 4 != 0 && slot_of(k) == 0 && k < 115) ? 8'hC5 : 8'hFF;
      checkOutput("all_blank", k, exp_an(k), es, (k < 115));
    end

    // Error accepted again, then a one-clock reset in the middle of slot 2
    for (int k = 128; k < 138; k++) begin
      applyStimulus(1'b0, 12'h800);
      if (k % 4 == 0)                      es = 8'hFF;
      else if (slot_of(k) == 0 && k < 131) es = 8'hFF;
      else                                 es = 8'hC5;
      checkOutput("pre_reset", k, exp_an(k), es, (k >= 131));
    end
    applyStimulus(1'b1, 12'h800);
    checkOutput("reset_mid_slot", 138, 4'hF, 8'hFF, 1'b0);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 12'h800);
      if (k % 4 == 0 || k < 3)  es = 8'hFF;
      else if (slot_of(k) == 3) es = 8'h61;
      else                      es = 8'hC5;
      checkOutput("after_reset", k, exp_an(k), es, (k >= 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
